// File: rtl/fetch_busio.sv
// Fetch-side bus responder: one-entry line buffer fed by a req/gnt + rvalid memory transaction.
// Latency: hit/misaligned answer combinationally; a miss seen in cycle N is ready in cycle N+3 at best.
// Backpressure: fetch_stall stays high until the word is buffered; mem_req/mem_addr hold until mem_gnt.
module fetch_busio #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          fetch_address,
    input  logic                 flush,
    output logic [31:0]          fetch_data,
    output logic                 fetch_ready,
    output logic                 fetch_stall,
    output logic                 fetch_fault,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_err,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        buf_valid;
    logic [29:0] buf_tag;
    logic [31:0] buf_data;
    logic        buf_err;
    logic        orphan;
    logic [29:0] req_tag;

    logic        misaligned;
    logic        hit;
    logic        issue;
    logic        resp;
    logic        fill;

    // Fetch-side answer is purely combinational on the buffer contents.
    assign misaligned  = |fetch_address[1:0];
    assign hit         = buf_valid && (buf_tag == fetch_address[31:2]);
    assign fetch_ready = misaligned || hit;
    assign fetch_fault = misaligned || (hit && buf_err);
    assign fetch_data  = (fetch_ready && !fetch_fault) ? buf_data : NOP_INSTR;
    assign fetch_stall = ~fetch_ready;

    // The request is exactly the REQ state; the address comes from the latched tag so it cannot move.
    assign mem_req  = (state == REQ);
    assign mem_addr = {req_tag, 2'b00};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle actions; a response arriving with flush is dropped but still retires the FSM.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        resp      = 1'b0;
        fill      = 1'b0;
        case (state)
            IDLE: begin
                if (!misaligned && !hit && !flush) begin
                    issue     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp      = 1'b1;
                    fill      = !orphan && !flush;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer, request tag, orphan marker and saturating miss counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid  <= 1'b0;
            buf_tag    <= '0;
            buf_data   <= '0;
            buf_err    <= 1'b0;
            orphan     <= 1'b0;
            req_tag    <= '0;
            miss_count <= '0;
        end else begin
            if (issue) begin
                req_tag <= fetch_address[31:2];
            end
            if (issue && (miss_count != '1)) begin
                miss_count <= miss_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                buf_valid <= 1'b0;
            end else if (fill) begin
                buf_valid <= 1'b1;
            end
            if (fill) begin
                buf_tag  <= req_tag;
                buf_data <= mem_rdata;
                buf_err  <= mem_err;
            end
            if (resp) begin
                orphan <= 1'b0;
            end else if (flush && (state != IDLE)) begin
                orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_busio.sv
// Bench for fetch_busio: memory responder with programmable delays, queue of expected fetch results,
// and a monitor that retires one expected entry each time the held fetch address is answered.
// A second instance with a 2-bit counter shares all inputs to observe counter saturation.
module tb_fetch_busio;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_address;
    logic        flush;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        fetch_stall;
    logic        fetch_fault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] miss_count;

    logic [31:0] s_fetch_data;
    logic        s_fetch_ready;
    logic        s_fetch_stall;
    logic        s_fetch_fault;
    logic        s_mem_req;
    logic [31:0] s_mem_addr;
    logic [1:0]  s_miss_count;

    always #5 clk = ~clk;

    fetch_busio #(.NOP_INSTR(NOP), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .fetch_address(fetch_address), .flush(flush),
        .fetch_data(fetch_data), .fetch_ready(fetch_ready), .fetch_stall(fetch_stall),
        .fetch_fault(fetch_fault), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err), .miss_count(miss_count)
    );

    fetch_busio #(.NOP_INSTR(NOP), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .fetch_address(fetch_address), .flush(flush),
        .fetch_data(s_fetch_data), .fetch_ready(s_fetch_ready), .fetch_stall(s_fetch_stall),
        .fetch_fault(s_fetch_fault), .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err), .miss_count(s_miss_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        sb_e;
    logic [31:0] gnt_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_req   = 0;
    int          g_delay = 0;
    int          rv_delay = 0;
    logic        fetch_req = 1'b0;
    logic        rnd_flush = 1'b0;
    logic        rsp_busy  = 1'b0;
    logic        prev_pend = 1'b0;
    logic        prev_req  = 1'b0;
    logic [31:0] prev_addr = '0;

    // Memory contents: one special word at the reset vector, a scrambled pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0297;
        return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'h0f0f};
    endfunction

    function automatic logic mem_bad(input logic [31:0] a);
        return (a == 32'h8000_0004) || ((a[31:28] == 4'h9) && (a[5:2] == 4'hb));
    endfunction

    function automatic logic [31:0] sat3(input int n);
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present an address and record what the fetch stage must eventually receive for it.
    task automatic issue(input logic [31:0] a);
        exp_t        e;
        logic [31:0] al;
        al      = {a[31:2], 2'b00};
        e.addr  = a;
        e.fault = (a[1:0] != 2'b00) || mem_bad(al);
        e.data  = e.fault ? NOP : mem_word(al);
        exp_q.push_back(e);
        fetch_address = a;
        fetch_req     = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget, output int lat);
        int start;
        start = n_done;
        lat   = 0;
        while (n_done == start && lat < budget) begin
            @(negedge clk); #1;
            lat++;
            flush = rnd_flush && (n_done == start) && ($urandom_range(0, 15) == 0);
        end
        flush = 1'b0;
        n_tests++;
        if (n_done == start) begin
            n_fail++;
            $display("FAIL %s: no fetch_ready within %0d cycles for 0x%08h", name, budget, fetch_address);
            if (exp_q.size() > 0) exp_q.delete(0);
        end
        fetch_req = 1'b0;
    endtask

    // Memory responder: grants after g_delay cycles, answers rvalid_delay cycles after the grant.
    initial begin : responder
        logic        gl;
        int          gcnt;
        int          rcnt;
        logic [31:0] raddr;
        gl = 1'b0; gcnt = 0; rcnt = 0; raddr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
            mem_rdata  = $urandom;
            if (gl) begin
                rsp_busy = 1'b1;
                rcnt     = 0;
                gl       = 1'b0;
            end
            if (rsp_busy) begin
                if (rcnt >= rv_delay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(raddr);
                    mem_err    = mem_bad(raddr);
                    rsp_busy   = 1'b0;
                end else begin
                    rcnt++;
                end
            end else if (mem_req) begin
                if (gcnt >= g_delay) begin
                    mem_gnt = 1'b1;
                    raddr   = mem_addr;
                    gl      = 1'b1;
                    gcnt    = 0;
                    gnt_log.push_back(mem_addr);
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // Bus-side protocol watch: held requests, request address, single outstanding, idle data.
    always @(negedge clk) begin
        if (!reset) begin
            n_req     = 0;
            prev_pend = 1'b0;
            prev_req  = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("req_held", {31'b0, mem_req}, 32'd1);
                chk("req_addr_stable", mem_addr, prev_addr);
            end
            if (mem_req && !prev_req) begin
                n_req++;
                chk("req_addr", mem_addr, {fetch_address[31:2], 2'b00});
            end
            if (rsp_busy) chk("one_outstanding", {31'b0, mem_req}, 32'd0);
            if (!fetch_ready) chk("nop_when_not_ready", fetch_data, NOP);
            chk("stall", {31'b0, fetch_stall}, {31'b0, !fetch_ready});
            prev_pend = mem_req && !mem_gnt;
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
    end

    // Retire one expected fetch result each time the presented address is answered.
    always @(negedge clk) begin
        if (reset && fetch_req && fetch_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: fetch_ready for 0x%08h with nothing expected", fetch_address);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_data", fetch_data, sb_e.data);
                chk("sb_fault", {31'b0, fetch_fault}, {31'b0, sb_e.fault});
                n_done++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int lat;
        int base;
        reset = 1'b0; flush = 1'b0; fetch_address = 32'h8000_0000;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        chk("rst_ready", {31'b0, fetch_ready}, 32'd0);
        chk("rst_data", fetch_data, NOP);
        #1; reset = 1'b1;

        // Reset while a response is pending; the late rvalid must not fill.
        rv_delay = 6; g_delay = 0;
        issue(32'h8000_0000);
        for (int i = 0; i < 20 && !rsp_busy; i++) begin @(negedge clk); #1; end
        chk("reach_wait", {31'b0, rsp_busy}, 32'd1);
        fetch_req = 1'b0;
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rstw_ready", {31'b0, fetch_ready}, 32'd0);
        chk("rstw_miss_count", miss_count, 32'd0);
        chk("rstw_sat_count", {30'b0, s_miss_count}, 32'd0);
        #1; reset = 1'b1; fetch_address = 32'h8000_0002;
        for (int i = 0; i < 20 && rsp_busy; i++) begin @(negedge clk); #1; end
        @(negedge clk); #1;
        fetch_address = 32'h8000_0000;
        #1; chk("late_rvalid_ignored", {31'b0, fetch_ready}, 32'd0);

        // First miss at minimum latency, then a repeat hit.
        rv_delay = 0;
        issue(32'h8000_0000);
        wait_done("miss0", 50, lat);
        chk("miss_latency", 32'(lat), 32'd3);
        chk("miss0_data", fetch_data, 32'h0000_0297);
        chk("miss_count_1", miss_count, 32'd1);
        chk("sat_count_1", {30'b0, s_miss_count}, 32'd1);
        base = n_req;
        issue(32'h8000_0000);
        #1; chk("hit_same_cycle", {31'b0, fetch_ready}, 32'd1);
        wait_done("hit0", 5, lat);
        repeat (3) @(negedge clk);
        #1;
        chk("hit_no_req", 32'(n_req), 32'(base));
        chk("miss_count_still_1", miss_count, 32'd1);

        // Misaligned address answers at once with a fault and no bus traffic.
        issue(32'h8000_0002);
        #1;
        chk("mis_ready", {31'b0, fetch_ready}, 32'd1);
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        chk("mis_data", fetch_data, NOP);
        chk("mis_no_req", {31'b0, mem_req}, 32'd0);
        wait_done("misaligned", 5, lat);

        // Flush in IDLE, then a withheld grant while the fetch address moves on.
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        g_delay = 5; base = n_req;
        issue(32'h8000_0000);
        repeat (3) @(negedge clk);
        #1;
        fetch_req = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        issue(32'h8000_0010);
        @(negedge clk);
        chk("req_kept_addr", mem_addr, 32'h8000_0000);
        chk("req_kept", {31'b0, mem_req}, 32'd1);
        #1;
        wait_done("redirect", 100, lat);
        chk("redirect_two_reqs", 32'(n_req), 32'(base + 2));
        chk("redirect_first_addr", gnt_log[$-1], 32'h8000_0000);
        chk("redirect_second_addr", gnt_log[$], 32'h8000_0010);
        g_delay = 0;

        // Flush while waiting for the response: no fill, same line requested again.
        rv_delay = 3; base = n_req;
        issue(32'h8000_0020);
        for (int i = 0; i < 20 && !rsp_busy; i++) begin @(negedge clk); #1; end
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 20 && !mem_rvalid; i++) begin @(negedge clk); #1; end
        @(negedge clk);
        chk("flush_wait_no_fill", {31'b0, fetch_ready}, 32'd0);
        #1;
        wait_done("flush_refetch", 100, lat);
        chk("flush_two_reqs", 32'(n_req), 32'(base + 2));
        chk("flush_refetch_addr", gnt_log[$], 32'h8000_0020);

        // Flush in the same cycle as rvalid discards the response.
        rv_delay = 1; base = n_req;
        issue(32'h8000_0030);
        for (int i = 0; i < 20 && !mem_rvalid; i++) begin @(negedge clk); #1; end
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        chk("flush_wins", {31'b0, fetch_ready}, 32'd0);
        wait_done("flush_rvalid_refetch", 100, lat);
        chk("flush_rvalid_two_reqs", 32'(n_req), 32'(base + 2));

        // Error response: faulting entry answers with NOP and stays without a retry.
        rv_delay = 0;
        issue(32'h8000_0004);
        wait_done("err", 50, lat);
        chk("err_ready", {31'b0, fetch_ready}, 32'd1);
        chk("err_fault", {31'b0, fetch_fault}, 32'd1);
        chk("err_data", fetch_data, NOP);
        base = n_req;
        issue(32'h8000_0004);
        #1; chk("err_sticky", {31'b0, fetch_fault}, 32'd1);
        wait_done("err_hit", 5, lat);
        repeat (2) @(negedge clk);
        #1;
        chk("err_no_retry", 32'(n_req), 32'(base));
        chk("miss_count_8", miss_count, 32'd8);
        chk("sat_stays_3", {30'b0, s_miss_count}, 32'd3);

        // Randomised fetch stream over a small line set with random delays and flushes.
        rnd_flush = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            g_delay  = $urandom_range(0, 3);
            rv_delay = $urandom_range(0, 3);
            a = 32'h9000_0000 + 32'($urandom_range(0, 15)) * 32'd4;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            issue(a);
            wait_done("rand", 100, lat);
        end
        rnd_flush = 1'b0;
        repeat (10) @(negedge clk);
        chk("rand_miss_count", miss_count, 32'(n_req));
        chk("rand_sat_count", {30'b0, s_miss_count}, sat3(n_req));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
